mux2_1f: RTL
============

# mux2_1f

Two-lane to one-lane byte un-striper, 9-bit words (8 data bits + valid). It sits at the receive end of a two-lane link and re-interleaves the two lane streams, striped lane0, lane1, lane0, …, into one ordered byte stream. Each lane has a small FIFO to absorb lane skew. Output order strictly alternates lanes starting at lane 0, so original byte order is preserved.

## Interface
Parameters:
- DEPTH, 4: entries per lane FIFO; power of two, ≥2.
- WIDTH, 9: word width; bit 0 = valid, bits [WIDTH-1:1] = data.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in0  input  WIDTH  lane 0 word; in0[0]=1 marks a valid word.
- in1  input  WIDTH  lane 1 word; in1[0]=1 marks a valid word.
- out0  output  WIDTH  merged stream word, registered; out0[0]=1 marks a valid word.
- overflow  output  2  sticky per-lane overflow flag, bit n for lane n.
- level0  output  $clog2(DEPTH)+1  lane 0 FIFO occupancy.
- level1  output  $clog2(DEPTH)+1  lane 1 FIFO occupancy.

## Operation
- Reset (reset=0, asynchronous):
  - out0=0, overflow=2'b00, level0=level1=0.
  - FIFO pointers cleared.
  - Expected-lane pointer `turn`=0.
  - FIFO contents need not be cleared.
- Write:
  - At each edge, lane n FIFO pushes in_n when in_n[0]==1.
  - Words with bit 0 = 0 are ignored entirely.
- Read, one candidate per cycle, from lane `turn` only:
  - FIFO[turn] non-empty: pop its head into out0 (valid bit stays 1), then toggle `turn`.
  - FIFO[turn] empty: out0 ← 0 (idle) and `turn` holds. Never skip to the other lane, even when it has data.
- Overflow:
  - A push into a full lane without a same-cycle pop from that lane drops the word.
  - The drop sets overflow[n], which holds until reset.
  - Full with a same-cycle pop: the push is accepted and the level stays DEPTH.
- Simultaneous events:
  - Both lanes may push in the same cycle, each into its own FIFO.
  - Push and pop on the same lane in the same cycle are allowed. The level changes by push − pop.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits with natural wrap-around.
  - full = MSBs differ and the remaining bits are equal; empty = pointers equal.
- Data: payload bits pass through unmodified; no reordering within a lane.

## Timing
- No combinational path from inputs to outputs; out0, overflow and level outputs are all registered.
- Latency:
  - A word pushed at edge N is poppable no earlier than edge N+1, so it is on out0 after edge N+1.
  - There is no bypass when the FIFO is empty.
- Throughput: one output word per cycle when both lanes keep up. Sustained demux-side rate (one valid word per lane every 2 cycles) never overflows with DEPTH≥2.
- level outputs reflect the post-edge occupancy.
- Reset asserted mid-stream:
  - All outputs go to their reset values immediately, with no clock edge needed.
  - Queued words are discarded.
  - After release, the first output comes from lane 0.
- Reset release: the first edge with reset=1 may already capture inputs.

## Structure
- Package mux2_1f_pkg holds:
  - the VALID_BIT=0 constant;
  - the lane index type (0..1);
  - the default WIDTH/DEPTH constants, shared with demux1_2f testbenches.
- One sub-module, lane_fifo: parameterized synchronous FIFO (push, pop, dout, full, empty, level), instantiated twice.
- The top level contains only the `turn` logic, the output register and the overflow flags.

## Test plan
- Reset check: assert reset=0 mid-stream → out0=9'h000, overflow=0, levels 0, asynchronously; after release, the first popped word is from lane 0.
- In-order merge:
  - Stimulus: drive the demux pattern, with in0=9'h003, 9'h007 on cycles 0 and 2, and in1=9'h005, 9'h009 on cycles 1 and 3.
  - Required: out0 sequence 003, 005, 007, 009, each appearing one edge after its push, with idle 000 between where a lane is empty.
- Skew hold:
  - Stimulus: push 4 words on lane 1 (9'h011, 013, 015, 017), then one lane 0 word 9'h021.
  - Required: out0 stays 000 until 021 appears, then 011 follows, strictly alternating lanes; level1 goes 4→3.
- Overflow:
  - Stimulus: with `turn` parked on lane 0 (lane 0 empty), push 5 valid words on lane 1.
  - Required: 5th word dropped, overflow=2'b10, level1=4; the sticky flag persists until reset.
- Invalid filtering: in0=9'h0FE (valid=0) on lane 0 → no push, level0 unchanged, out0 unaffected.
- Full with simultaneous pop: lane 0 full and `turn`=0, push 9'h0AB → pop and push both occur, level0 remains 4, overflow[0]=0, and 0AB emerges in order later.

Source files
------------

// File: rtl/mux2_1f_pkg.sv
// Shared constants and types for the two-lane byte un-striper and its companion benches.
package mux2_1f_pkg;

  localparam int unsigned VALID_BIT     = 0;
  localparam int unsigned DEFAULT_WIDTH = 9;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic {
    Lane0 = 1'b0,
    Lane1 = 1'b1
  } lane_e;

endpackage

// File: rtl/mux2_1f_if.sv
// Lane inputs and merged-stream/status outputs of the un-striper, grouped as one bundle.
interface mux2_1f_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] out0;
  logic [1:0]       overflow;
  logic [LW-1:0]    level0;
  logic [LW-1:0]    level1;

  modport master (
    output in0,
    output in1,
    input  out0,
    input  overflow,
    input  level0,
    input  level1
  );

  modport slave (
    input  in0,
    input  in1,
    output out0,
    output overflow,
    output level0,
    output level1
  );

endinterface

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when the same cycle also pops.
module lane_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    level = wptr_q - rptr_q;
    dout  = mem_q[rptr_q[AW-1:0]];
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW + 1)'(1);
      if (rd_en) rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mux2_1f.sv
// Two-lane to one-lane un-striper: strictly alternates lanes starting at lane 0,
// waiting on the expected lane rather than skipping ahead.
module mux2_1f
  import mux2_1f_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       reset,
  mux2_1f_if.slave  bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             push0, push1, pop0, pop1;
  logic             full0, full1, empty0, empty1;
  logic [WIDTH-1:0] dout0, dout1;
  logic [LW-1:0]    level0, level1;

  lane_e            turn_q, turn_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       ovf_q, ovf_d;

  lane_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .din   (bus.in0),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0),
    .level (level0)
  );

  lane_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .din   (bus.in1),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1),
    .level (level1)
  );

  always_comb begin
    push0  = bus.in0[VALID_BIT];
    push1  = bus.in1[VALID_BIT];
    pop0   = (turn_q == Lane0) && !empty0;
    pop1   = (turn_q == Lane1) && !empty1;
    out_d  = '0;
    turn_d = turn_q;
    if (pop0) begin
      out_d  = dout0;
      turn_d = Lane1;
    end else if (pop1) begin
      out_d  = dout1;
      turn_d = Lane0;
    end
    // A word is dropped only when its lane is full and not draining this cycle.
    ovf_d = ovf_q | {push1 && full1 && !pop1, push0 && full0 && !pop0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_q <= Lane0;
      out_q  <= '0;
      ovf_q  <= '0;
    end else begin
      turn_q <= turn_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out0     = out_q;
  assign bus.overflow = ovf_q;
  assign bus.level0   = level0;
  assign bus.level1   = level1;

endmodule
